// File: rtl/mp_add_sub_seq_if.sv
// Operand/result bundle for the sequential multi-precision add/subtract unit.
// Master drives the start request and operands; slave returns result and status.
interface mp_add_sub_seq_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NWORDS = 4
);
  logic                      i_start;
  logic                      i_op;
  logic [WIDTH*NWORDS-1:0]   i_a;
  logic [WIDTH*NWORDS-1:0]   i_b;
  logic [WIDTH*NWORDS-1:0]   o_res;
  logic                      o_c;
  logic                      o_busy;
  logic                      o_done;

  modport master (
    output i_start, i_op, i_a, i_b,
    input  o_res, o_c, o_busy, o_done
  );

  modport slave (
    input  i_start, i_op, i_a, i_b,
    output o_res, o_c, o_busy, o_done
  );
endinterface

// File: rtl/mp_add_sub_seq.sv
// Sequential multi-precision add/subtract: one WIDTH-bit word per clock, LSW first,
// carry/borrow held between words; result and carry-out published with a done pulse.
module mp_add_sub_seq #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NWORDS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  mp_add_sub_seq_if.slave  bus
);
  localparam int unsigned TW = WIDTH * NWORDS;
  localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   a_reg, b_reg, work, work_nxt, res_reg;
  logic            op_reg, carry_reg, c_reg;
  logic [IW-1:0]   idx;
  logic [WIDTH-1:0] a_w, b_sel, b_w, sum;
  logic            cout;
  logic            last;

  assign last = (idx == LAST_IDX);

  // Word select, one ripple-add step, and the work value with the current word merged in.
  always_comb begin
    a_w      = '0;
    b_sel    = '0;
    work_nxt = work;
    for (int unsigned w = 0; w < NWORDS; w++) begin
      if (idx == IW'(w)) begin
        a_w   = a_reg[w*WIDTH +: WIDTH];
        b_sel = b_reg[w*WIDTH +: WIDTH];
      end
    end
    b_w         = op_reg ? ~b_sel : b_sel;
    {cout, sum} = {1'b0, a_w} + {1'b0, b_w} + {{WIDTH{1'b0}}, carry_reg};
    for (int unsigned w = 0; w < NWORDS; w++) begin
      if (idx == IW'(w)) work_nxt[w*WIDTH +: WIDTH] = sum;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_start) state_nxt = RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
      work      <= '0;
      res_reg   <= '0;
      c_reg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            a_reg     <= bus.i_a;
            b_reg     <= bus.i_b;
            op_reg    <= bus.i_op;
            carry_reg <= bus.i_op;
            idx       <= '0;
            work      <= '0;
          end
        end
        RUN: begin
          work      <= work_nxt;
          carry_reg <= cout;
          if (last) begin
            // Publish on the same edge as the last word so DONE sees the full result.
            res_reg <= work_nxt;
            c_reg   <= op_reg ^ cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_res  = res_reg;
  assign bus.o_c    = c_reg;
  assign bus.o_busy = (state != IDLE);
  assign bus.o_done = (state == DONE);
endmodule

// File: tb/tb_mp_add_sub_seq.sv
// Self-checking bench: 16-bit (4x4) and 8-bit single-word instances, scoreboard of
// expected results pushed at start and popped on done.
module tb_mp_add_sub_seq;
  typedef struct {
    logic [15:0] res;
    logic        c;
  } sb_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  sb_t  sb16[$];
  sb_t  sb8[$];
  logic [15:0] last_res16 = '0;
  logic        last_c16   = 1'b0;
  logic [7:0]  last_res8  = '0;
  logic        last_c8    = 1'b0;

  mp_add_sub_seq_if #(.WIDTH(4), .NWORDS(4)) bus();
  mp_add_sub_seq_if #(.WIDTH(8), .NWORDS(1)) bus8();

  mp_add_sub_seq #(.WIDTH(4), .NWORDS(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );
  mp_add_sub_seq #(.WIDTH(8), .NWORDS(1)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic sb_t model16(input logic [15:0] a, input logic [15:0] b, input logic op);
    sb_t r;
    logic [16:0] s;
    if (!op) begin
      s     = {1'b0, a} + {1'b0, b};
      r.res = s[15:0];
      r.c   = s[16];
    end else begin
      r.res = a - b;
      r.c   = (a < b);
    end
    return r;
  endfunction

  function automatic sb_t model8(input logic [7:0] a, input logic [7:0] b, input logic op);
    sb_t r;
    logic [8:0] s;
    r.res = '0;
    if (!op) begin
      s          = {1'b0, a} + {1'b0, b};
      r.res[7:0] = s[7:0];
      r.c        = s[8];
    end else begin
      r.res[7:0] = a - b;
      r.c        = (a < b);
    end
    return r;
  endfunction

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic op);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_a = a; bus.i_b = b; bus.i_op = op;
    sb16.push_back(model16(a, b, op));
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_a     = 16'($urandom);
    bus.i_b     = 16'($urandom);
    bus.i_op    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait16(output int lat, output int busy_n, output bit stable);
    lat = -1; busy_n = 0; stable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.o_busy) busy_n++;
      if (bus.o_done) begin
        lat = k;
        break;
      end
      if (bus.o_res !== last_res16 || bus.o_c !== last_c16) stable = 1'b0;
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic op);
    @(negedge clk);
    bus8.i_start = 1'b1; bus8.i_a = a; bus8.i_b = b; bus8.i_op = op;
    sb8.push_back(model8(a, b, op));
    @(posedge clk);
    #1;
    bus8.i_start = 1'b0;
    bus8.i_a     = 8'($urandom);
    bus8.i_b     = 8'($urandom);
    bus8.i_op    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait8(output int lat);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus8.o_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_op = 1'b0; bus.i_a = '0; bus.i_b = '0;
    bus8.i_start = 1'b0; bus8.i_op = 1'b0; bus8.i_a = '0; bus8.i_b = '0;
    @(negedge clk);
    n_checks++;
    if (bus.o_res !== 16'h0) $display("FAIL reset_res: got %h want 0000", bus.o_res); else n_pass++;
    n_checks++;
    if (bus.o_c !== 1'b0) $display("FAIL reset_c: got %b want 0", bus.o_c); else n_pass++;
    n_checks++;
    if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.o_busy); else n_pass++;
    n_checks++;
    if (bus.o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.o_done); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table16(input string name, input logic [15:0] ta[], input logic [15:0] tb[],
                             input logic top[]);
    int  lat, busy_n;
    bit  stable;
    sb_t exp;
    for (int i = 0; i < ta.size(); i++) begin
      issue16(ta[i], tb[i], top[i]);
      wait16(lat, busy_n, stable);
      exp = sb16.pop_front();
      n_checks++;
      if (lat !== 5) $display("FAIL %s_lat[%0d]: got %0d want 5", name, i, lat); else n_pass++;
      n_checks++;
      if (busy_n !== 5) $display("FAIL %s_busy[%0d]: got %0d want 5", name, i, busy_n); else n_pass++;
      n_checks++;
      if (bus.o_res !== exp.res) $display("FAIL %s_res[%0d]: got %h want %h", name, i, bus.o_res, exp.res); else n_pass++;
      n_checks++;
      if (bus.o_c !== exp.c) $display("FAIL %s_c[%0d]: got %b want %b", name, i, bus.o_c, exp.c); else n_pass++;
      n_checks++;
      if (!stable) $display("FAIL %s_stable[%0d]: output changed before done", name, i); else n_pass++;
      last_res16 = exp.res;
      last_c16   = exp.c;
    end
  endtask

  task automatic test_add;
    run_table16("add", '{16'h1234, 16'hFFFF}, '{16'h4321, 16'h0001}, '{1'b0, 1'b0});
  endtask

  task automatic test_sub;
    run_table16("sub", '{16'h1000, 16'h0001}, '{16'h0001, 16'h0002}, '{1'b1, 1'b1});
  endtask

  task automatic test_random;
    logic [15:0] ra[];
    logic [15:0] rb[];
    logic        ro[];
    ra = new[6]; rb = new[6]; ro = new[6];
    for (int i = 0; i < 6; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      ro[i] = 1'($urandom_range(0, 1));
    end
    run_table16("rand", ra, rb, ro);
  endtask

  task automatic test_back_to_back;
    int  kd, lat, busy_n;
    bit  stable;
    sb_t exp;
    issue16(16'h00FF, 16'h0001, 1'b0);
    kd = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) begin
        bus.i_start = 1'b1; bus.i_a = 16'hAAAA; bus.i_b = 16'h5555; bus.i_op = 1'b1;
      end
      if (bus.o_done) begin
        kd = k;
        break;
      end
    end
    exp = sb16.pop_front();
    n_checks++;
    if (kd !== 5) $display("FAIL b2b_lat: got %0d want 5", kd); else n_pass++;
    n_checks++;
    if (bus.o_res !== exp.res || bus.o_c !== exp.c)
      $display("FAIL b2b_res: got %h/%b want %h/%b", bus.o_res, bus.o_c, exp.res, exp.c);
    else n_pass++;
    last_res16 = exp.res;
    last_c16   = exp.c;
    // Start still held high: ignored while in DONE, accepted from the following IDLE cycle.
    @(negedge clk);
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0)
      $display("FAIL b2b_idle: got busy=%b done=%b want 0/0", bus.o_busy, bus.o_done);
    else n_pass++;
    sb16.push_back(model16(16'hAAAA, 16'h5555, 1'b1));
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    wait16(lat, busy_n, stable);
    exp = sb16.pop_front();
    n_checks++;
    if (lat !== 5) $display("FAIL b2b_next_lat: got %0d want 5", lat); else n_pass++;
    n_checks++;
    if (bus.o_res !== exp.res || bus.o_c !== exp.c)
      $display("FAIL b2b_next_res: got %h/%b want %h/%b", bus.o_res, bus.o_c, exp.res, exp.c);
    else n_pass++;
    last_res16 = exp.res;
    last_c16   = exp.c;
  endtask

  task automatic test_reset_mid;
    int  dones, lat, busy_n;
    bit  stable, bad;
    sb_t exp;
    issue16(16'hFFFF, 16'hFFFF, 1'b0);
    sb16.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_res !== 16'h0 || bus.o_c !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0)
      $display("FAIL rstmid_outs: got res=%h c=%b busy=%b done=%b want all 0",
               bus.o_res, bus.o_c, bus.o_busy, bus.o_done);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    last_res16 = '0;
    last_c16   = 1'b0;
    dones = 0; bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.o_done) dones++;
      if (bus.o_busy || bus.o_res !== 16'h0 || bus.o_c) bad = 1'b1;
    end
    n_checks++;
    if (dones !== 0) $display("FAIL rstmid_nodone: got %0d done pulses want 0", dones); else n_pass++;
    n_checks++;
    if (bad) $display("FAIL rstmid_idle: outputs nonzero after aborted op want 0"); else n_pass++;
    issue16(16'h0003, 16'h0001, 1'b1);
    wait16(lat, busy_n, stable);
    exp = sb16.pop_front();
    n_checks++;
    if (lat !== 5) $display("FAIL rstmid_after_lat: got %0d want 5", lat); else n_pass++;
    n_checks++;
    if (bus.o_res !== exp.res || bus.o_c !== exp.c)
      $display("FAIL rstmid_after_res: got %h/%b want %h/%b", bus.o_res, bus.o_c, exp.res, exp.c);
    else n_pass++;
    last_res16 = exp.res;
    last_c16   = exp.c;
  endtask

  task automatic test_single_word;
    logic [7:0] ta[3] = '{8'h80, 8'h05, 8'hC3};
    logic [7:0] tb[3] = '{8'h80, 8'h07, 8'h3C};
    logic       top[3] = '{1'b0, 1'b1, 1'b1};
    int  lat;
    sb_t exp;
    for (int i = 0; i < 3; i++) begin
      issue8(ta[i], tb[i], top[i]);
      wait8(lat);
      exp = sb8.pop_front();
      n_checks++;
      if (lat !== 2) $display("FAIL w1_lat[%0d]: got %0d want 2", i, lat); else n_pass++;
      n_checks++;
      if (bus8.o_res !== exp.res[7:0]) $display("FAIL w1_res[%0d]: got %h want %h", i, bus8.o_res, exp.res[7:0]); else n_pass++;
      n_checks++;
      if (bus8.o_c !== exp.c) $display("FAIL w1_c[%0d]: got %b want %b", i, bus8.o_c, exp.c); else n_pass++;
      last_res8 = exp.res[7:0];
      last_c8   = exp.c;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_single_word();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
